// File: rtl/mealy_table_fsm.sv
// Table-driven Mealy state machine: transitions and outputs come from a reloadable
// table indexed by {state_index, in}; state port encoding and output timing are selectable.
module mealy_table_fsm #(
   parameter int unsigned ST_NUM  = 5,
   parameter int unsigned IN_W    = 2,
   parameter int unsigned OUT_W   = 2,
   parameter int unsigned ENC     = 2,
   parameter int unsigned REG_OUT = 0,
   localparam int unsigned SI_W   = $clog2(ST_NUM),
   localparam int unsigned ST_W   = (ENC == 0) ? SI_W : ST_NUM,
   localparam int unsigned AW     = SI_W + IN_W,
   localparam int unsigned DW     = SI_W + OUT_W
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             en,
   input  logic [IN_W-1:0]  in,
   output logic [OUT_W-1:0] out,
   output logic [ST_W-1:0]  state,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [DW-1:0]    cfg_data,
   output logic             cfg_err,
   output logic             err
);

   localparam int unsigned TBL_N = ST_NUM << IN_W;

   logic [DW-1:0]    tbl [TBL_N];
   logic [SI_W-1:0]  idx;
   logic [SI_W-1:0]  nxt_idx;
   logic [DW-1:0]    rd;
   logic [SI_W-1:0]  ent_next;
   logic [OUT_W-1:0] ent_out;
   logic [OUT_W-1:0] out_c;
   logic             illegal_c;
   logic             addr_ok_c;

   // Lookup always reads the pre-edge table content, so a same-cycle rewrite is seen next cycle
   assign rd       = tbl[{idx, in}];
   assign ent_next = rd[DW-1:OUT_W];
   assign ent_out  = rd[OUT_W-1:0];
   assign addr_ok_c = ({1'b0, cfg_addr[AW-1:IN_W]} < (SI_W+1)'(ST_NUM));

   // Configuration table; cleared by reset and must be reloaded afterwards
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int unsigned i = 0; i < TBL_N; i++) begin
            tbl[AW'(i)] <= '0;
         end
      end else if (cfg_we && addr_ok_c) begin
         tbl[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !addr_ok_c;
      end
   end

   // State register and sticky illegal-transition flag
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         idx <= '0;
         err <= 1'b0;
      end else begin
         idx <= nxt_idx;
         err <= err | illegal_c;
      end
   end

   // Next state: out-of-range next index falls back to S0
   always_comb begin
      nxt_idx   = idx;
      illegal_c = 1'b0;
      if (en) begin
         if ({1'b0, ent_next} < (SI_W+1)'(ST_NUM)) begin
            nxt_idx = ent_next;
         end else begin
            nxt_idx   = '0;
            illegal_c = 1'b1;
         end
      end
   end

   // Output: entry value while running, zero while halted
   always_comb begin
      out_c = '0;
      if (en) begin
         out_c = ent_out;
      end
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [OUT_W-1:0] out_q;
         always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
               out_q <= '0;
            end else begin
               out_q <= out_c;
            end
         end
         assign out = out_q;
      end else begin : g_comb_out
         assign out = out_c;
      end
   endgenerate

   // State port is a pure decode of the index, so it can never show an illegal code
   generate
      if (ENC == 0) begin : g_enc_bin
         assign state = idx;
      end else if (ENC == 1) begin : g_enc_hot
         assign state = ST_W'(1) << idx;
      end else begin : g_enc_cold
         assign state = ~(ST_W'(1) << idx);
      end
   endgenerate

endmodule

// File: doc/mealy_table_fsm.md
Name: mealy_table_fsm

Overview:
Parametrised, table-driven Mealy state machine engine. It generalises the team's hand-coded 5-state, 2-input, 2-output one-cold FSMs, so new controllers are loaded through a configuration port instead of being recoded. Supports selectable state encoding (binary / one-hot / one-cold), combinational or registered outputs, run enable, and illegal-state recovery. Sits next to lab/exam datapaths as a reusable control unit.

Parameters:
ST_NUM, 5, number of states (2..16); state index 0 is the reset state S0
IN_W, 2, input vector width (1..4)
OUT_W, 2, output vector width (1..8)
ENC, 2, state encoding on state port: 0 binary, 1 one-hot, 2 one-cold
REG_OUT, 0, 0 = Mealy combinational outputs, 1 = outputs registered (one cycle later)
Derived: SI_W = clog2(ST_NUM); ST_W = SI_W if ENC=0, else ST_NUM; AW = SI_W+IN_W; DW = SI_W+OUT_W

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
en  input  1  run enable; state advances only when 1
in  input  IN_W  FSM inputs (MSB first, e.g. {a,b})
out  output  OUT_W  FSM outputs (e.g. {m,n})
state  output  ST_W  current state, encoded per ENC
cfg_we  input  1  table write strobe
cfg_addr  input  AW  entry address = {state_index, in}
cfg_data  input  DW  entry = {next_index, out_value}
cfg_err  output  1  one-cycle pulse: write to out-of-range address
err  output  1  sticky: illegal next index taken; cleared only by reset

Behaviour:
- Reset (async, rst_b=0): state index 0 (ENC=0 -> 0; ENC=1 -> bit0 set; ENC=2 -> all ones except bit0 = 0, e.g. 5'b11110 for ST_NUM=5, bit i low marks state i). All table entries = {0,0}. out=0, cfg_err=0, err=0.
- Lookup: entry = table[{cur_index, in}]. Entry-derived out is combinational when REG_OUT=0; when REG_OUT=1, out is registered at the same edge that updates state (value from the pre-edge state/inputs).
- en=0: state holds. With REG_OUT=0, out forced 0. With REG_OUT=1, out register loads 0. Config writes still accepted.
- en=1, rising edge: state <= next_index from the entry.
- Illegal next: next_index >= ST_NUM -> state goes to S0 instead; err set (sticky). Same-cycle out still taken from the entry.
- Config write: at rising edge with cfg_we=1, table[cfg_addr] <= cfg_data. A write takes effect from the next cycle. Same-cycle lookup of the same entry uses the old content.
- Address range: cfg_addr with state field >= ST_NUM -> write ignored, cfg_err=1 for exactly one cycle.
- Simultaneous cfg write + state advance: both occur. No stall.
- State decode: the internal index is the source of truth and the state port is a pure function of it, so an illegal encoding on the port is impossible.
- Reset mid-operation: immediate return to reset values. The table is cleared and must be reloaded.
- Latency: REG_OUT=0 -> out valid same cycle as in. REG_OUT=1 -> one cycle later.

Test Plan:
- Reset, ENC=2, ST_NUM=5 -> state=5'b11110, out=2'b00, err=0. Raise rst_b, apply no writes, in=2'b11 for 3 cycles -> state stays 5'b11110 (all entries next=0).
- Load the classic 5-state table (e.g. S0: in=0x->{S0,00}, 11->{S4,10}, 10->{S1,01}; S1 any->{S2,11}; rest per the hand-coded controller). Drive in=10,xx,11 -> state indices 0->1->2->3, out 01,11,10.
- REG_OUT=1, same sequence -> out lags by exactly one cycle; first post-reset cycle out=00.
- Load entry {0,00}->{next=7,out=01} with ST_NUM=5 and apply in=00 -> out=01 that cycle, next state S0, err=1 and stays 1 until rst_b=0.
- Write cfg_addr={3'd6,2'b00} with ST_NUM=5 -> cfg_err=1 for one cycle, table unchanged. Rewrite the current entry while en=1 -> the old next state is used that edge, the new one from the next visit.
- en=0 for 4 cycles mid-run -> state frozen, out=00. ENC=0/1 builds -> state=3'd2 / 5'b00100 for index 2.
